// File: rtl/alu_pkg.sv
// Shared ALU definitions: default operand width, divider FSM states and
// the signed range limits used by the divider.
package alu_pkg;

  localparam int DEF_WIDTH = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [DEF_WIDTH-1:0] SMAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam logic [DEF_WIDTH-1:0] SMIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

endpackage

// File: rtl/div_seq_if.sv
// Start/busy/done handshake and operand/result bus between the control unit
// (master) and the sequential divider (slave).
interface div_seq_if
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] arg1;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             div_zero;
  logic             ovf;

  modport master (
    output start, acc, arg1,
    input  busy, done, quot, rem, div_zero, ovf
  );

  modport slave (
    input  start, acc, arg1,
    output busy, done, quot, rem, div_zero, ovf
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift the partial remainder left, bring in the
// next dividend bit, trial-subtract the divisor and restore on a borrow.
module div_step
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             dvd_msb_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_bit_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // Partial remainder stays below the divisor, so the top bit of diff is a
  // reliable borrow flag.
  always_comb begin
    shifted = {rem_i, dvd_msb_i};
    diff    = shifted - {2'b00, dvs_i};
    q_bit_o = ~diff[WIDTH+1];
    rem_o   = q_bit_o ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/div_seq.sv
// Sequential signed divider: magnitude restoring division one bit per clock,
// with sign fix-up, overflow saturation and divide-by-zero handling.
module div_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic      clk,
  input  logic      rst_n,
  div_seq_if.slave  bus
);

  localparam int               CW     = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] SMAX_W = {1'b0, {(WIDTH-1){1'b1}}};

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             div_zero_q, div_zero_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (prem_q),
    .dvd_msb_i (dq_q[WIDTH-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q)
  );

  // dq_q shifts dividend bits out of the top while quotient bits enter below.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prem_d     = prem_q;
    dq_d       = dq_q;
    dvs_d      = dvs_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;
    q_mag      = {dq_q[WIDTH-2:0], step_q};
    r_mag      = step_rem[WIDTH-1:0];

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          div_zero_d = 1'b0;
          ovf_d      = 1'b0;
          if (bus.arg1 == '0) begin
            state_d    = ST_DONE;
            quot_d     = '0;
            rem_d      = bus.acc;
            div_zero_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            cnt_d   = CW'(WIDTH-1);
            prem_d  = '0;
            dq_d    = bus.acc[WIDTH-1]  ? -bus.acc  : bus.acc;
            dvs_d   = bus.arg1[WIDTH-1] ? -bus.arg1 : bus.arg1;
            q_neg_d = bus.acc[WIDTH-1] ^ bus.arg1[WIDTH-1];
            r_neg_d = bus.acc[WIDTH-1];
          end
        end
      end

      ST_RUN: begin
        prem_d = step_rem;
        dq_d   = q_mag;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          // A positive quotient with the top bit set only arises from SMIN / -1.
          if (!q_neg_q && q_mag[WIDTH-1]) begin
            quot_d = SMAX_W;
            rem_d  = '0;
            ovf_d  = 1'b1;
          end else begin
            quot_d = q_neg_q ? -q_mag : q_mag;
            rem_d  = r_neg_q ? -r_mag : r_mag;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      prem_q     <= '0;
      dq_q       <= '0;
      dvs_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prem_q     <= prem_d;
      dq_q       <= dq_d;
      dvs_q      <= dvs_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.busy     = (state_q == ST_RUN);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.quot     = quot_q;
  assign bus.rem      = rem_q;
  assign bus.div_zero = div_zero_q;
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: hand-computed quotients and
// remainders, handshake latency, ignored starts and mid-operation reset.
module tb_div_seq;
  import alu_pkg::*;

  localparam int W = 11;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;
  int   busyCnt;
  int   doneSeen;

  div_seq_if #(.WIDTH(W)) bus ();

  div_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse start for one accepted edge, then scramble the operands.
  task automatic applyStimulus(input int a, input int b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.acc   = W'(a);
    bus.arg1  = W'(b);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.acc   = W'($urandom);
    bus.arg1  = W'($urandom);
  endtask

  // Counts negedges after the accepting edge until done; cyc=0 on timeout.
  task automatic waitDone(output int c, output int b);
    c = 0;
    b = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.busy) b++;
      if (bus.done) begin
        c = k;
        break;
      end
    end
  endtask

  task automatic checkResult(input string tag, input int q, input int r,
                             input int o, input int z);
    checkOutput({tag, ".quot"}, int'($signed(bus.quot)), q);
    checkOutput({tag, ".rem"}, int'($signed(bus.rem)), r);
    checkOutput({tag, ".ovf"}, int'(bus.ovf), o);
    checkOutput({tag, ".div_zero"}, int'(bus.div_zero), z);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.acc   = '0;
    bus.arg1  = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset.busy", int'(bus.busy), 0);
    checkOutput("reset.done", int'(bus.done), 0);
    checkResult("reset", 0, 0, 0, 0);
    rst_n = 1'b1;

    $display("[TB] 900 / 7");
    applyStimulus(900, 7);
    waitDone(cyc, busyCnt);
    checkOutput("900/7.latency", cyc, 12);
    checkOutput("900/7.busy_cycles", busyCnt, 11);
    checkResult("900/7", 128, 4, 0, 0);
    @(negedge clk);
    checkOutput("900/7.done_pulse", int'(bus.done), 0);
    checkOutput("900/7.busy_after", int'(bus.busy), 0);
    checkOutput("900/7.quot_held", int'($signed(bus.quot)), 128);

    $display("[TB] sign combinations");
    applyStimulus(-50, 7);
    waitDone(cyc, busyCnt);
    checkResult("-50/7", -7, -1, 0, 0);
    applyStimulus(50, -7);
    waitDone(cyc, busyCnt);
    checkResult("50/-7", -7, 1, 0, 0);
    applyStimulus(-27, -25);
    waitDone(cyc, busyCnt);
    checkResult("-27/-25", 1, -2, 0, 0);

    $display("[TB] overflow boundary");
    applyStimulus(-1024, -1);
    waitDone(cyc, busyCnt);
    checkResult("-1024/-1", int'($signed(SMAX)), 0, 1, 0);
    applyStimulus(-1024, 1);
    waitDone(cyc, busyCnt);
    checkResult("-1024/1", int'($signed(SMIN)), 0, 0, 0);

    $display("[TB] divide by zero");
    applyStimulus(5, 0);
    waitDone(cyc, busyCnt);
    checkOutput("5/0.latency", cyc, 1);
    checkOutput("5/0.busy_cycles", busyCnt, 0);
    checkResult("5/0", 0, 5, 0, 1);

    $display("[TB] start while busy");
    applyStimulus(900, 7);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.acc   = W'(50);
    bus.arg1  = W'(5);
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(cyc, busyCnt);
    checkOutput("ignore.latency", cyc, 8);
    checkResult("ignore", 128, 4, 0, 0);

    $display("[TB] start held across done");
    @(negedge clk);
    bus.start = 1'b1;
    bus.acc   = W'(-50);
    bus.arg1  = W'(7);
    @(posedge clk);
    #1;
    bus.acc  = W'(50);
    bus.arg1 = W'(-7);
    waitDone(cyc, busyCnt);
    checkOutput("b2b1.latency", cyc, 12);
    checkResult("b2b1", -7, -1, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    waitDone(cyc, busyCnt);
    checkOutput("b2b2.latency", cyc, 12);
    checkResult("b2b2", -7, 1, 0, 0);

    $display("[TB] reset during run");
    applyStimulus(900, 7);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort.busy", int'(bus.busy), 0);
    checkOutput("abort.done", int'(bus.done), 0);
    checkResult("abort", 0, 0, 0, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    doneSeen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) doneSeen++;
    end
    checkOutput("abort.no_done", doneSeen, 0);
    applyStimulus(-900, -105);
    waitDone(cyc, busyCnt);
    checkOutput("-900/-105.latency", cyc, 12);
    checkResult("-900/-105", 8, -60, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
